// File: rtl/text_seq_pkg.sv
`default_nettype none
// text_seq_pkg: shared types and defaults for the text-line sequencer and its watchdog.
package text_seq_pkg;

   localparam int COLOR_W     = 4;
   localparam int DY_W        = 4;
   localparam int DEF_GLYPH_W = 8;
   localparam int DEF_GLYPH_H = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_NEXT  = 2'd3
   } state_e;

endpackage
`default_nettype wire

// File: rtl/text_seq_watchdog.sv
`default_nettype none
// text_seq_watchdog: counts cycles spent waiting on the renderer and flags expiry.
module text_seq_watchdog #(
   parameter int TIMEOUT_CYC = 64
)(
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic run_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] count_q;

   // count holds (wait cycles elapsed - 1), so expiry lands on the TIMEOUT_CYC-th wait cycle
   assign expired_o = run_i && (count_q == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (run_i && !expired_o) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/text_line_sequencer.sv
`default_nettype none
// text_line_sequencer: walks one text line row-major, one renderer start per character per glyph row.
// Optional renderer watchdog (abort with err=1) enabled by defining TEXT_LINE_SEQUENCER_TIMEOUT_EN.
module text_line_sequencer
   import text_seq_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int X_W         = 10,
   parameter int Y_W         = 9,
   parameter int GLYPH_W     = DEF_GLYPH_W,
   parameter int GLYPH_H     = DEF_GLYPH_H,
   parameter int TIMEOUT_CYC = 64
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [ADDR_W-1:0]  cmd_base,
   input  logic [7:0]         cmd_len,
   input  logic [X_W-1:0]     cmd_x,
   input  logic [Y_W-1:0]     cmd_y,
   input  logic [COLOR_W-1:0] cmd_fg,
   input  logic [COLOR_W-1:0] cmd_bg,
   output logic               su_start,
   output logic [ADDR_W-1:0]  su_addr,
   output logic [DY_W-1:0]    su_delta_y,
   output logic [COLOR_W-1:0] su_fg,
   output logic [COLOR_W-1:0] su_bg,
   input  logic               su_done,
   output logic [X_W-1:0]     org_x,
   output logic [Y_W-1:0]     org_y,
   output logic               busy,
   output logic               line_done,
   output logic               err
);

   state_e              state_q;
   logic [ADDR_W-1:0]   base_q;
   logic [7:0]          len_q;
   logic [7:0]          idx_q;
   logic [7:0]          idx_d;
   logic [X_W-1:0]      x_q;
   logic                cmd_ready_q;
   logic                su_start_q;
   logic [ADDR_W-1:0]   su_addr_q;
   logic [DY_W-1:0]     su_delta_y_q;
   logic [COLOR_W-1:0]  su_fg_q;
   logic [COLOR_W-1:0]  su_bg_q;
   logic [X_W-1:0]      org_x_q;
   logic [Y_W-1:0]      org_y_q;
   logic                busy_q;
   logic                line_done_q;
   logic                err_q;
   logic                w_last_char;
   logic                w_last_row;
   logic                w_expired;

   assign w_last_char = (idx_q == len_q - 8'd1);
   assign w_last_row  = (su_delta_y_q == DY_W'(GLYPH_H - 1));
   assign idx_d       = w_last_char ? 8'd0 : idx_q + 8'd1;

`ifdef TEXT_LINE_SEQUENCER_TIMEOUT_EN
   text_seq_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_watchdog (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (state_q == S_ISSUE),
      .run_i     (state_q == S_WAIT),
      .expired_o (w_expired)
   );
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT_CYC;
   assign w_expired        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         base_q       <= '0;
         len_q        <= '0;
         idx_q        <= '0;
         x_q          <= '0;
         cmd_ready_q  <= 1'b1;
         su_start_q   <= 1'b0;
         su_addr_q    <= '0;
         su_delta_y_q <= '0;
         su_fg_q      <= '0;
         su_bg_q      <= '0;
         org_x_q      <= '0;
         org_y_q      <= '0;
         busy_q       <= 1'b0;
         line_done_q  <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         line_done_q <= 1'b0;
         err_q       <= 1'b0;
         su_start_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid && cmd_ready_q) begin
                  base_q       <= cmd_base;
                  len_q        <= cmd_len;
                  x_q          <= cmd_x;
                  idx_q        <= '0;
                  su_addr_q    <= cmd_base;
                  su_delta_y_q <= '0;
                  su_fg_q      <= cmd_fg;
                  su_bg_q      <= cmd_bg;
                  org_x_q      <= cmd_x;
                  org_y_q      <= cmd_y;
                  if (cmd_len != 8'd0) begin
                     state_q     <= S_ISSUE;
                     su_start_q  <= 1'b1;
                     busy_q      <= 1'b1;
                     cmd_ready_q <= 1'b0;
                  end else begin
                     line_done_q <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               // a done arriving on the expiry cycle takes priority over the abort
               if (su_done) begin
                  state_q <= S_NEXT;
               end else if (w_expired) begin
                  state_q     <= S_IDLE;
                  busy_q      <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  line_done_q <= 1'b1;
                  err_q       <= 1'b1;
               end
            end
            S_NEXT: begin
               idx_q     <= idx_d;
               su_addr_q <= base_q + ADDR_W'(idx_d);
               if (w_last_char) begin
                  org_x_q      <= x_q;
                  su_delta_y_q <= su_delta_y_q + DY_W'(1);
                  org_y_q      <= org_y_q + Y_W'(1);
               end else begin
                  org_x_q <= org_x_q + X_W'(GLYPH_W);
               end
               if (w_last_char && w_last_row) begin
                  state_q     <= S_IDLE;
                  busy_q      <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  line_done_q <= 1'b1;
               end else begin
                  state_q    <= S_ISSUE;
                  su_start_q <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign su_start   = su_start_q;
   assign su_addr    = su_addr_q;
   assign su_delta_y = su_delta_y_q;
   assign su_fg      = su_fg_q;
   assign su_bg      = su_bg_q;
   assign org_x      = org_x_q;
   assign org_y      = org_y_q;
   assign busy       = busy_q;
   assign line_done  = line_done_q;
   assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_text_line_sequencer.sv
`default_nettype none
// tb_text_line_sequencer: randomized self-checking bench with a renderer model and a row-major reference model.
module tb_text_line_sequencer;

   localparam int ADDR_W  = 12;
   localparam int X_W     = 10;
   localparam int Y_W     = 9;
   localparam int GLYPH_W = 8;
   localparam int GLYPH_H = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_base = '0;
   logic [7:0]        cmd_len = '0;
   logic [X_W-1:0]    cmd_x = '0;
   logic [Y_W-1:0]    cmd_y = '0;
   logic [3:0]        cmd_fg = '0;
   logic [3:0]        cmd_bg = '0;
   logic              su_start;
   logic [ADDR_W-1:0] su_addr;
   logic [3:0]        su_delta_y;
   logic [3:0]        su_fg;
   logic [3:0]        su_bg;
   logic              su_done = 1'b0;
   logic [X_W-1:0]    org_x;
   logic [Y_W-1:0]    org_y;
   logic              busy;
   logic              line_done;
   logic              err;

   text_line_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_base   (cmd_base),
      .cmd_len    (cmd_len),
      .cmd_x      (cmd_x),
      .cmd_y      (cmd_y),
      .cmd_fg     (cmd_fg),
      .cmd_bg     (cmd_bg),
      .su_start   (su_start),
      .su_addr    (su_addr),
      .su_delta_y (su_delta_y),
      .su_fg      (su_fg),
      .su_bg      (su_bg),
      .su_done    (su_done),
      .org_x      (org_x),
      .org_y      (org_y),
      .busy       (busy),
      .line_done  (line_done),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [3:0]        dy;
      logic [X_W-1:0]    ox;
      logic [Y_W-1:0]    oy;
      logic [3:0]        fg;
      logic [3:0]        bg;
   } glyph_t;

   glyph_t obs_q[$];
   glyph_t exp_q[$];
   glyph_t mon_g;
   int     ld_cyc[$];
   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   int     n_start = 0, n_ld = 0, ld_err = 0, first_start_cyc = -1;
   int     last_start_cyc = -100, gap_viol = 0, rdy_low = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // monitor: sampled on the falling edge, away from the DUT's active edge
   always @(negedge clk) begin
      if (su_start) begin
         if (n_start == 0) first_start_cyc = cyc;
         else if (cyc - last_start_cyc < 3) gap_viol++;
         last_start_cyc = cyc;
         n_start++;
         mon_g = '{addr: su_addr, dy: su_delta_y, ox: org_x, oy: org_y, fg: su_fg, bg: su_bg};
         obs_q.push_back(mon_g);
      end
      if (line_done) begin
         n_ld++;
         ld_err = int'(err);
         ld_cyc.push_back(cyc);
      end
      if (!cmd_ready) rdy_low++;
   end

   // renderer model: done rend_lat cycles after start (rend_lat==0 -> random); optional spurious dones outside WAIT
   int rend_lat = 9;
   bit rend_en = 1'b1;
   bit spur_en = 1'b0;
   int rend_cnt = 0;
   always @(negedge clk) begin
      su_done = 1'b0;
      if (reset) begin
         rend_cnt = 0;
      end else begin
         if (rend_cnt > 0) begin
            rend_cnt--;
            if (rend_cnt == 0) su_done = 1'b1;
         end else if (spur_en && $urandom_range(0, 2) == 0) begin
            su_done = 1'b1;
         end
         if (su_start && rend_en) rend_cnt = (rend_lat > 0) ? rend_lat : int'($urandom_range(1, 12));
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_mon();
      obs_q.delete();
      exp_q.delete();
      ld_cyc.delete();
      n_start = 0; n_ld = 0; ld_err = 0; first_start_cyc = -1; gap_viol = 0; rdy_low = 0;
   endtask

   // reference model: every glyph row, every character, with wrapping coordinate arithmetic
   function automatic void push_model(input int b, input int l, input int x, input int y, input int f, input int g);
      glyph_t e;
      for (int r = 0; r < GLYPH_H; r++) begin
         for (int i = 0; i < l; i++) begin
            e.addr = ADDR_W'((b + i) % (1 << ADDR_W));
            e.dy   = 4'(r);
            e.ox   = X_W'((x + i * GLYPH_W) % (1 << X_W));
            e.oy   = Y_W'((y + r) % (1 << Y_W));
            e.fg   = 4'(f);
            e.bg   = 4'(g);
            exp_q.push_back(e);
         end
      end
   endfunction

   task automatic issue_cmd(input int b, input int l, input int x, input int y, input int f, input int g,
                            output int acc, output bit ok);
      cmd_base  = ADDR_W'(b);
      cmd_len   = 8'(l);
      cmd_x     = X_W'(x);
      cmd_y     = Y_W'(y);
      cmd_fg    = 4'(f);
      cmd_bg    = 4'(g);
      cmd_valid = 1'b1;
      ok  = 1'b0;
      acc = -1;
      for (int i = 0; i < 5000; i++) begin
         if (cmd_ready) begin
            acc = cyc;
            ok  = 1'b1;
            tick();
            break;
         end
         tick();
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_ld(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (n_ld >= target) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      repeat (4) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b expected 1", cmd_ready);
      end
      checks++;
      if ({su_start, busy, line_done, err} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags: got %b expected 0000", {su_start, busy, line_done, err});
      end
      checks++;
      if ({su_addr, su_delta_y, su_fg, su_bg, org_x, org_y} !== '0) begin
         errors++; $display("FAIL reset_fields: got %h expected 0", {su_addr, su_delta_y, su_fg, su_bg, org_x, org_y});
      end
   endtask

   task automatic test_basic();
      int acc; bit ok, ok2;
      clear_mon(); rend_lat = 9; spur_en = 1'b0;
      push_model('h100, 3, 16, 40, 'hF, 'h1);
      issue_cmd('h100, 3, 16, 40, 'hF, 'h1, acc, ok);
      wait_ld(1, 2000, ok2);
      checks++;
      if (!(ok && ok2)) begin errors++; $display("FAIL basic_timeout: accepted %b done %b expected 1 1", ok, ok2); end
      checks++;
      if (n_start !== 24) begin errors++; $display("FAIL basic_count: got %0d expected 24", n_start); end
      checks++;
      if (first_start_cyc !== acc + 1) begin
         errors++; $display("FAIL basic_latency: got %0d expected %0d", first_start_cyc, acc + 1);
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_glyph%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
      end
      checks++;
      if (n_ld !== 1 || ld_err !== 0) begin errors++; $display("FAIL basic_done: got n=%0d err=%0d expected n=1 err=0", n_ld, ld_err); end
      checks++;
      if (gap_viol !== 0) begin errors++; $display("FAIL basic_gap: got %0d expected 0", gap_viol); end
   endtask

   task automatic test_zero_len();
      int acc; bit ok, ok2;
      clear_mon();
      issue_cmd(int'($urandom_range(0, 4095)), 0, 5, 6, 2, 3, acc, ok);
      wait_ld(1, 50, ok2);
      checks++;
      if (!(ok && ok2) || n_ld !== 1) begin errors++; $display("FAIL zero_done: got n=%0d expected 1", n_ld); end
      else begin
         checks++;
         if (ld_cyc[0] !== acc + 1) begin errors++; $display("FAIL zero_latency: got %0d expected %0d", ld_cyc[0], acc + 1); end
      end
      checks++;
      if (n_start !== 0 || ld_err !== 0) begin errors++; $display("FAIL zero_start: got starts=%0d err=%0d expected 0 0", n_start, ld_err); end
      checks++;
      if (rdy_low !== 0) begin errors++; $display("FAIL zero_ready: got %0d low cycles expected 0", rdy_low); end
   endtask

   task automatic test_wrap();
      int acc; bit ok, ok2;
      clear_mon(); rend_lat = 3; spur_en = 1'b0;
      push_model('hFFF, 2, 1020, 508, 3, 'hC);
      issue_cmd('hFFF, 2, 1020, 508, 3, 'hC, acc, ok);
      wait_ld(1, 1000, ok2);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL wrap_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_glyph%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int acc_a, acc_b, la, lb; bit ok_a, ok_b, ok2;
      clear_mon(); rend_lat = 0; spur_en = 1'b1;
      la = int'($urandom_range(1, 4));
      lb = int'($urandom_range(1, 4));
      push_model('h020, la, 100, 200, 5, 6);
      push_model('h7F0, lb, 300, 10, 9, 'hA);
      issue_cmd('h020, la, 100, 200, 5, 6, acc_a, ok_a);
      issue_cmd('h7F0, lb, 300, 10, 9, 'hA, acc_b, ok_b);
      wait_ld(2, 3000, ok2);
      spur_en = 1'b0;
      checks++;
      if (!(ok_a && ok_b && ok2) || n_ld !== 2) begin errors++; $display("FAIL b2b_done: got n=%0d expected 2", n_ld); end
      else begin
         checks++;
         if (acc_b !== ld_cyc[0]) begin errors++; $display("FAIL b2b_accept: got cycle %0d expected %0d", acc_b, ld_cyc[0]); end
      end
      checks++;
      if (n_start !== GLYPH_H * (la + lb)) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", n_start, GLYPH_H * (la + lb)); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_glyph%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
      end
      checks++;
      if (gap_viol !== 0 || ld_err !== 0) begin errors++; $display("FAIL b2b_gap: got gaps=%0d err=%0d expected 0 0", gap_viol, ld_err); end
   endtask

   task automatic test_reset_mid();
      int acc; bit ok, ok2, found;
      clear_mon(); rend_lat = 6; spur_en = 1'b0;
      issue_cmd('h300, 3, 50, 60, 1, 2, acc, ok);
      found = 1'b0;
      for (int i = 0; i < 1000 && !found; i++) begin
         if (su_start && su_delta_y == 4'd3) found = 1'b1;
         else tick();
      end
      checks++;
      if (!found) begin errors++; $display("FAIL rstmid_row3: got no row-3 start expected one"); end
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({busy, su_start, cmd_ready} !== 3'b001) begin
         errors++; $display("FAIL rstmid_state: got busy/start/ready=%b expected 001", {busy, su_start, cmd_ready});
      end
      clear_mon();
      repeat (20) tick();
      checks++;
      if (n_start !== 0 || n_ld !== 0) begin errors++; $display("FAIL rstmid_quiet: got starts=%0d dones=%0d expected 0 0", n_start, n_ld); end
      clear_mon();
      push_model('h0A0, 2, 8, 16, 7, 8);
      issue_cmd('h0A0, 2, 8, 16, 7, 8, acc, ok);
      wait_ld(1, 1000, ok2);
      checks++;
      if (obs_q.size() !== exp_q.size() || n_ld !== 1) begin
         errors++; $display("FAIL rstmid_rerun: got %0d starts %0d dones expected %0d 1", obs_q.size(), n_ld, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_glyph%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_random();
      int acc, b, l, x, y, f, g; bit ok, ok2;
      for (int n = 0; n < 4; n++) begin
         clear_mon(); rend_lat = 0; spur_en = 1'b1;
         b = int'($urandom_range(0, 4095)); l = int'($urandom_range(1, 5));
         x = int'($urandom_range(0, 1023)); y = int'($urandom_range(0, 511));
         f = int'($urandom_range(0, 15));   g = int'($urandom_range(0, 15));
         push_model(b, l, x, y, f, g);
         issue_cmd(b, l, x, y, f, g, acc, ok);
         wait_ld(1, 3000, ok2);
         spur_en = 1'b0;
         checks++;
         if (obs_q.size() !== exp_q.size() || n_ld !== 1 || ld_err !== 0) begin
            errors++; $display("FAIL rand%0d_summary: got %0d starts n=%0d err=%0d expected %0d 1 0", n, obs_q.size(), n_ld, ld_err, exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_glyph%0d: got %h expected %h", n, i, obs_q[i], exp_q[i]); end
         end
      end
   endtask

`ifdef TEXT_LINE_SEQUENCER_TIMEOUT_EN
   task automatic test_timeout();
      int acc; bit ok, ok2;
      clear_mon(); rend_en = 1'b0; spur_en = 1'b0;
      issue_cmd('h010, 2, 0, 0, 1, 1, acc, ok);
      wait_ld(1, 300, ok2);
      checks++;
      if (!(ok && ok2) || n_ld !== 1) begin errors++; $display("FAIL tmo_done: got n=%0d expected 1", n_ld); end
      else begin
         checks++;
         if (ld_cyc[0] !== acc + 66 || ld_err !== 1) begin
            errors++; $display("FAIL tmo_abort: got cycle %0d err %0d expected %0d 1", ld_cyc[0], ld_err, acc + 66);
         end
      end
      checks++;
      if (n_start !== 1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL tmo_state: got starts=%0d ready=%b expected 1 1", n_start, cmd_ready); end
      clear_mon(); rend_en = 1'b1; rend_lat = 64;
      push_model('h020, 1, 4, 4, 2, 2);
      issue_cmd('h020, 1, 4, 4, 2, 2, acc, ok);
      wait_ld(1, 2000, ok2);
      checks++;
      if (n_ld !== 1 || ld_err !== 0 || n_start !== GLYPH_H) begin
         errors++; $display("FAIL tmo_edge: got n=%0d err=%0d starts=%0d expected 1 0 %0d", n_ld, ld_err, n_start, GLYPH_H);
      end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      test_random();
`ifdef TEXT_LINE_SEQUENCER_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
